core_dispatcher: RTL and testbench
==================================

# core_dispatcher

Sequencer that owns the single shared message bus into the core monitor and the event queue. It pops events from the queue head and assigns them to idle cores, and round-robin arbitrates cores returning generated events or completion messages. Each cycle it issues at most one transaction, spaced so the monitor's registered match and minimum-finding pipeline always sees a stable `core_id`. The block sits between the event queue, the core array and the core monitor, and is the only driver of the monitor's `msg`, `sent_msg_vld`, `rcv_msg_vld`, `core_id` and `core_active` inputs.

## Interface
- `NUM_CORE`, 4: number of cores; power of two, at least 2.
- `NB_COREID`, `$clog2(NUM_CORE)`: core id width.
- `TIME_WID`, 16: timestamp width.
- `MSG_WID`, 32: event message width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `q_vld`  in  1  queue head valid.
- `q_msg`  in  MSG_WID  queue head event.
- `q_deq`  out  1  pop pulse for the queue head.
- `enq_rdy`  in  1  queue can accept an enqueue.
- `enq_vld`  out  1  enqueue strobe.
- `enq_msg`  out  MSG_WID  event to enqueue.
- `core_req`  in  NUM_CORE  core i has a message to return; held until granted.
- `core_last`  in  NUM_CORE  the returned message is core i's completion message.
- `core_msg`  in  NUM_CORE*MSG_WID  returned messages; core i uses `[i*MSG_WID +: MSG_WID]`.
- `core_gnt`  out  NUM_CORE  one-hot grant pulse.
- `core_evt_vld`  out  NUM_CORE  one-hot new-event delivery pulse.
- `core_evt_msg`  out  MSG_WID  delivered event, shared by all cores.
- `mon_msg`  out  MSG_WID  message to the monitor.
- `mon_sent_vld`  out  1  dispatch strobe to the monitor.
- `mon_rcv_vld`  out  1  completion strobe to the monitor.
- `mon_core_id`  out  NB_COREID  core id of the current transaction.
- `core_active`  out  NUM_CORE  registered busy map.

## Operation
- FSM has two states, ARB and ISSUE. Reset state is ARB.
- In ARB, compute the eligible transactions:
  - Return-eligible core i: `core_req[i] && core_active[i] && (core_last[i] || enq_rdy)`. Requests from inactive cores are ignored.
  - Dispatch-eligible: `q_vld && ~&core_active`. Target core is the lowest-index inactive core.
- Choosing between the two:
  - If both kinds are eligible, pick dispatch when `last_was_ret`=1, otherwise pick return.
  - `last_was_ret` updates on every issued transaction; its reset value is 0.
- Return selection is round-robin. The pointer starts at 0 and moves to granted index + 1 (mod NUM_CORE) after each grant.
- When a transaction is chosen, the FSM moves to ISSUE. The issue cycle has these effects:
  - Dispatch: `q_deq`=1, `mon_sent_vld`=1, `core_evt_vld[target]`=1, `mon_msg`=`core_evt_msg`=captured `q_msg`, `mon_core_id`=target. `core_active[target]` is set and is visible in the same cycle.
  - Return with last=0: `core_gnt[i]`=1, `enq_vld`=1, `enq_msg`=`core_msg[i]`. No monitor strobe; `mon_core_id`=i.
  - Return with last=1: `core_gnt[i]`=1, `mon_rcv_vld`=1, `mon_msg`=`core_msg[i]`, `mon_core_id`=i. No enqueue. `core_active[i]` clears and is visible in the same cycle.
- ISSUE always returns to ARB. No decision is made while in ISSUE.
- Mutual exclusion: `mon_sent_vld` and `mon_rcv_vld` are never both 1. Only one of `q_deq`, `enq_vld` and `mon_rcv_vld` fires per issue.
- Reset at any point: the next cycle has all outputs at 0, `core_active`=0, FSM in ARB, round-robin pointer at 0 and `last_was_ret`=0. Any in-flight transaction is dropped.

## Timing
- All outputs are registered. Every output resets to 0.
- Latency is one cycle: a decision in ARB at cycle t produces its strobes in cycle t+1 only.
- Throughput is one transaction per 2 cycles. The ARB cycle acts as the mandatory idle gap on the monitor bus.
- `mon_msg` and `mon_core_id` hold their last values when idle. Consumers qualify them with the strobes.
- Inputs `q_msg`, `core_msg`, `core_last` and `enq_rdy` are sampled at the ARB edge. Requesters must hold them stable until the grant or pop.
- A core freed by a last=1 return at t+1 becomes eligible for dispatch in the ARB cycle at t+2; its earliest new event arrives at t+3.
- All cores active with `q_vld`=1: no dispatch is issued and no `q_deq` fires. The queue head is held.
- `enq_rdy`=0: last=0 returns stall, while last=1 returns proceed.

## Structure
- Shared package:
  - Message field constants: time at `[0 +: TIME_WID]`, LP id at `[TIME_WID +: NB_LPID]`, history size at `[MSG_WID-1 -: NB_HIST_DEPTH]`.
  - FSM state enum.
- Sub-module `rr_arbiter`, parameterised by N. Inputs: request vector and an advance strobe. Output: one-hot grant. It holds the pointer internally.

## Test plan
- Reset, then `q_vld`=1 with time 0x0010: `q_deq`, `mon_sent_vld` and `core_evt_vld`=0001 all fire in cycle 2 with `mon_core_id`=0, and `core_active`=0001 from that cycle on.
- Four dispatches in sequence fill all cores. A fifth `q_vld` then gets no `q_deq` until core 2 returns a last=1 message, after which the next dispatch targets core 2.
- Cores 0–3 all request with last=0 and `enq_rdy`=1: grants come in order 0,1,2,3, spaced 2 cycles apart.
- A return and a dispatch are pending continuously: issues alternate return, dispatch, return, and `mon_sent_vld`/`mon_rcv_vld` never overlap.
- `enq_rdy`=0 with core 1 last=0 and core 3 last=1 pending: core 3 is granted and `mon_rcv_vld`=1, while core 1 waits until `enq_rdy`=1.
- `reset` asserted in an ISSUE cycle: all strobes are 0 in the next cycle, `core_active`=0, and arbitration restarts at core 0.

Source files
------------

// File: rtl/core_dispatcher_pkg.sv
// rtl/core_dispatcher_pkg.sv - shared message field layout and FSM state type for core_dispatcher
package core_dispatcher_pkg;

   // Message layout: time in the low bits, LP id above it, history size at the top.
   localparam int TIME_LSB      = 0;
   localparam int NB_LPID       = 8;
   localparam int NB_HIST_DEPTH = 4;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_ISSUE = 1'b1
   } disp_state_e;

   function automatic int lpid_lsb(input int time_wid);
      return TIME_LSB + time_wid;
   endfunction

   function automatic int hist_msb(input int msg_wid);
      return msg_wid - 1;
   endfunction

endpackage

// File: rtl/core_dispatcher_rr_arbiter.sv
// rtl/core_dispatcher_rr_arbiter.sv - round-robin arbiter; pointer moves past the winner on advance
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req_i,
   input  logic         adv_i,
   output logic [N-1:0] gnt_o
);

   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] idx;
   logic [W-1:0] win;
   logic         found;

   // Scan from the pointer upward, wrapping; N is a power of two so W-bit overflow wraps.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      win   = ptr_q;
      idx   = ptr_q;
      for (int k = 0; k < N; k++) begin
         idx = ptr_q + W'(k);
         if (!found && req_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      if (found) begin
         gnt_o[win] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (adv_i && found) begin
         ptr_d = win + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/core_dispatcher.sv
// rtl/core_dispatcher.sv - owns the monitor bus; dispatches queue events to idle cores and arbitrates core returns
module core_dispatcher
   import core_dispatcher_pkg::*;
#(
   parameter int NUM_CORE  = 4,
   parameter int NB_COREID = $clog2(NUM_CORE),
   parameter int TIME_WID  = 16,
   parameter int MSG_WID   = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      q_vld,
   input  logic [MSG_WID-1:0]        q_msg,
   output logic                      q_deq,
   input  logic                      enq_rdy,
   output logic                      enq_vld,
   output logic [MSG_WID-1:0]        enq_msg,
   input  logic [NUM_CORE-1:0]       core_req,
   input  logic [NUM_CORE-1:0]       core_last,
   input  logic [NUM_CORE*MSG_WID-1:0] core_msg,
   output logic [NUM_CORE-1:0]       core_gnt,
   output logic [NUM_CORE-1:0]       core_evt_vld,
   output logic [MSG_WID-1:0]        core_evt_msg,
   output logic [MSG_WID-1:0]        mon_msg,
   output logic                      mon_sent_vld,
   output logic                      mon_rcv_vld,
   output logic [NB_COREID-1:0]      mon_core_id,
   output logic [NUM_CORE-1:0]       core_active
);

   if ((NUM_CORE < 2) || ((NUM_CORE & (NUM_CORE - 1)) != 0) ||
       (TIME_WID + NB_LPID + NB_HIST_DEPTH > MSG_WID)) begin : g_param_err
      $error("core_dispatcher: unsupported parameter set");
   end

   disp_state_e           state_q, state_d;
   logic                  last_ret_q, last_ret_d;
   logic [NUM_CORE-1:0]   active_q, active_d;
   logic                  q_deq_q, q_deq_d;
   logic                  enq_vld_q, enq_vld_d;
   logic [MSG_WID-1:0]    enq_msg_q, enq_msg_d;
   logic [NUM_CORE-1:0]   gnt_q, gnt_d;
   logic [NUM_CORE-1:0]   evt_vld_q, evt_vld_d;
   logic [MSG_WID-1:0]    evt_msg_q, evt_msg_d;
   logic [MSG_WID-1:0]    mon_msg_q, mon_msg_d;
   logic                  sent_q, sent_d;
   logic                  rcv_q, rcv_d;
   logic [NB_COREID-1:0]  id_q, id_d;

   logic [NUM_CORE-1:0]   ret_elig;
   logic [NUM_CORE-1:0]   rr_gnt;
   logic                  ret_any;
   logic                  disp_elig;
   logic                  pick_ret;
   logic [NB_COREID-1:0]  disp_idx;
   logic [NB_COREID-1:0]  ret_idx;
   logic [MSG_WID-1:0]    ret_msg;

   // A non-final return needs queue space; a completion never does.
   assign ret_elig  = core_req & active_q & (core_last | {NUM_CORE{enq_rdy}});
   assign ret_any   = |ret_elig;
   assign disp_elig = q_vld & ~(&active_q);

   rr_arbiter #(
      .N (NUM_CORE)
   ) u_rr (
      .clk   (clk),
      .reset (reset),
      .req_i (ret_elig),
      .adv_i (pick_ret),
      .gnt_o (rr_gnt)
   );

   always_comb begin
      disp_idx = '0;
      for (int i = NUM_CORE - 1; i >= 0; i--) begin
         if (!active_q[i]) begin
            disp_idx = NB_COREID'(i);
         end
      end
      ret_idx = '0;
      for (int i = 0; i < NUM_CORE; i++) begin
         if (rr_gnt[i]) begin
            ret_idx = NB_COREID'(i);
         end
      end
   end

   assign ret_msg = core_msg[ret_idx*MSG_WID +: MSG_WID];

   always_comb begin
      state_d    = state_q;
      last_ret_d = last_ret_q;
      active_d   = active_q;
      q_deq_d    = 1'b0;
      enq_vld_d  = 1'b0;
      gnt_d      = '0;
      evt_vld_d  = '0;
      sent_d     = 1'b0;
      rcv_d      = 1'b0;
      enq_msg_d  = enq_msg_q;
      evt_msg_d  = evt_msg_q;
      mon_msg_d  = mon_msg_q;
      id_d       = id_q;
      pick_ret   = 1'b0;
      case (state_q)
         ST_ARB: begin
            // Alternate kinds when both are pending so neither side starves.
            if (disp_elig && (!ret_any || last_ret_q)) begin
               state_d             = ST_ISSUE;
               last_ret_d          = 1'b0;
               active_d[disp_idx]  = 1'b1;
               q_deq_d             = 1'b1;
               sent_d              = 1'b1;
               evt_vld_d[disp_idx] = 1'b1;
               mon_msg_d           = q_msg;
               evt_msg_d           = q_msg;
               id_d                = disp_idx;
            end else if (ret_any) begin
               pick_ret   = 1'b1;
               state_d    = ST_ISSUE;
               last_ret_d = 1'b1;
               gnt_d      = rr_gnt;
               id_d       = ret_idx;
               if (core_last[ret_idx]) begin
                  rcv_d             = 1'b1;
                  mon_msg_d         = ret_msg;
                  active_d[ret_idx] = 1'b0;
               end else begin
                  enq_vld_d = 1'b1;
                  enq_msg_d = ret_msg;
               end
            end
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_ARB;
         last_ret_q <= 1'b0;
         active_q   <= '0;
         q_deq_q    <= 1'b0;
         enq_vld_q  <= 1'b0;
         enq_msg_q  <= '0;
         gnt_q      <= '0;
         evt_vld_q  <= '0;
         evt_msg_q  <= '0;
         mon_msg_q  <= '0;
         sent_q     <= 1'b0;
         rcv_q      <= 1'b0;
         id_q       <= '0;
      end else begin
         state_q    <= state_d;
         last_ret_q <= last_ret_d;
         active_q   <= active_d;
         q_deq_q    <= q_deq_d;
         enq_vld_q  <= enq_vld_d;
         enq_msg_q  <= enq_msg_d;
         gnt_q      <= gnt_d;
         evt_vld_q  <= evt_vld_d;
         evt_msg_q  <= evt_msg_d;
         mon_msg_q  <= mon_msg_d;
         sent_q     <= sent_d;
         rcv_q      <= rcv_d;
         id_q       <= id_d;
      end
   end

   assign q_deq        = q_deq_q;
   assign enq_vld      = enq_vld_q;
   assign enq_msg      = enq_msg_q;
   assign core_gnt     = gnt_q;
   assign core_evt_vld = evt_vld_q;
   assign core_evt_msg = evt_msg_q;
   assign mon_msg      = mon_msg_q;
   assign mon_sent_vld = sent_q;
   assign mon_rcv_vld  = rcv_q;
   assign mon_core_id  = id_q;
   assign core_active  = active_q;

endmodule

// File: tb/tb_core_dispatcher.sv
// tb/tb_core_dispatcher.sv - vector table, directed corner sequences and random traffic against a transaction model
module tb_core_dispatcher;

   logic        clk;
   logic        reset;
   logic        q_vld;
   logic [31:0] q_msg;
   logic        q_deq;
   logic        enq_rdy;
   logic        enq_vld;
   logic [31:0] enq_msg;
   logic [3:0]  core_req;
   logic [3:0]  core_last;
   logic [127:0] core_msg;
   logic [3:0]  core_gnt;
   logic [3:0]  core_evt_vld;
   logic [31:0] core_evt_msg;
   logic [31:0] mon_msg;
   logic        mon_sent_vld;
   logic        mon_rcv_vld;
   logic [1:0]  mon_core_id;
   logic [3:0]  core_active;

   logic [31:0] core_msg_a [4];
   assign core_msg = {core_msg_a[3], core_msg_a[2], core_msg_a[1], core_msg_a[0]};

   core_dispatcher #(
      .NUM_CORE (4),
      .TIME_WID (16),
      .MSG_WID  (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .q_vld        (q_vld),
      .q_msg        (q_msg),
      .q_deq        (q_deq),
      .enq_rdy      (enq_rdy),
      .enq_vld      (enq_vld),
      .enq_msg      (enq_msg),
      .core_req     (core_req),
      .core_last    (core_last),
      .core_msg     (core_msg),
      .core_gnt     (core_gnt),
      .core_evt_vld (core_evt_vld),
      .core_evt_msg (core_evt_msg),
      .mon_msg      (mon_msg),
      .mon_sent_vld (mon_sent_vld),
      .mon_rcv_vld  (mon_rcv_vld),
      .mon_core_id  (mon_core_id),
      .core_active  (core_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Transaction-level model: one decision per ARB cycle, following the dispatch/return rules.
   bit [3:0]    m_act;
   int          m_ptr;
   bit          m_lr, m_iss, m_ok;
   logic        e_deq, e_enq, e_sent, e_rcv;
   logic [3:0]  e_gnt, e_evt;
   logic [1:0]  e_id;
   logic [31:0] e_mon, e_enq_msg, e_evt_msg;
   int          cyc_n = 0;
   int          overlap = 0;
   int          lg_code[$];
   int          lg_cyc[$];

   initial m_ok = 1'b0;

   always @(posedge clk) begin
      int rp, dp, gi;
      cyc_n++;
      if (reset) begin
         m_act = '0; m_ptr = 0; m_lr = 0; m_iss = 0; m_ok = 1;
         e_deq = 0; e_enq = 0; e_sent = 0; e_rcv = 0; e_gnt = '0; e_evt = '0;
         e_id = '0; e_mon = '0;
      end else if (m_ok) begin
         e_deq = 0; e_enq = 0; e_sent = 0; e_rcv = 0; e_gnt = '0; e_evt = '0;
         if (m_iss) begin
            m_iss = 0;
         end else begin
            rp = -1;
            for (int k = 0; k < 4; k++) begin
               int i;
               i = (m_ptr + k) % 4;
               if (rp < 0 && core_req[i] && m_act[i] && (core_last[i] || enq_rdy)) rp = i;
            end
            dp = -1;
            if (q_vld) for (int i = 0; i < 4; i++) if (dp < 0 && !m_act[i]) dp = i;
            if (dp >= 0 && (rp < 0 || m_lr)) begin
               e_deq = 1; e_sent = 1; e_evt[dp] = 1; e_mon = q_msg; e_evt_msg = q_msg;
               e_id = 2'(dp); m_act[dp] = 1; m_lr = 0; m_iss = 1;
            end else if (rp >= 0) begin
               e_gnt[rp] = 1; e_id = 2'(rp); m_ptr = (rp + 1) % 4; m_lr = 1; m_iss = 1;
               if (core_last[rp]) begin
                  e_rcv = 1; e_mon = core_msg_a[rp]; m_act[rp] = 0;
               end else begin
                  e_enq = 1; e_enq_msg = core_msg_a[rp];
               end
            end
         end
      end
      #1;
      if (m_ok) begin
         chk($sformatf("model@%0d", cyc_n),
             {q_deq, enq_vld, mon_sent_vld, mon_rcv_vld, core_gnt, core_evt_vld, mon_core_id, core_active, mon_msg},
             {e_deq, e_enq, e_sent, e_rcv, e_gnt, e_evt, e_id, m_act, e_mon});
         if (e_enq) chk($sformatf("enq_msg@%0d", cyc_n), enq_msg, e_enq_msg);
         if (e_evt != 0) chk($sformatf("evt_msg@%0d", cyc_n), core_evt_msg, e_evt_msg);
      end
      if (mon_sent_vld && mon_rcv_vld) overlap++;
      if (q_deq) begin
         lg_code.push_back(int'(mon_core_id)); lg_cyc.push_back(cyc_n);
      end else if (core_gnt != 0) begin
         gi = 0;
         for (int i = 0; i < 4; i++) if (core_gnt[i]) gi = i;
         lg_code.push_back((mon_rcv_vld ? 32 : 16) + gi); lg_cyc.push_back(cyc_n);
      end
   end

   function automatic int lg_at(input int k);
      return (k < lg_code.size()) ? lg_code[k] : -1;
   endfunction

   function automatic int gap_at(input int k);
      return (k < lg_cyc.size() && k > 0) ? lg_cyc[k] - lg_cyc[k-1] : -1;
   endfunction

   // Environment: queue behind q_vld/q_msg, requesters that hold until granted.
   logic [31:0] evq[$];
   bit auto_env = 0, rnd = 0, keep0 = 0;

   task automatic cyc();
      @(negedge clk);
      if (auto_env) begin
         if (q_deq && evq.size() > 0) void'(evq.pop_front());
         if (enq_vld) evq.push_back(enq_msg);
         for (int i = 0; i < 4; i++) if (core_gnt[i]) core_req[i] = 1'b0;
         if (keep0 && !core_req[0]) begin
            core_req[0] = 1'b1; core_last[0] = 1'b0; core_msg_a[0] = 32'hA000_0000 + 32'(cyc_n);
         end
         if (rnd) begin
            if ($urandom_range(0, 3) == 0 && evq.size() < 6) evq.push_back($urandom);
            for (int i = 0; i < 4; i++) begin
               if (!core_req[i] && $urandom_range(0, 5) == 0) begin
                  core_req[i] = 1'b1; core_last[i] = 1'($urandom_range(0, 1)); core_msg_a[i] = $urandom;
               end
            end
            enq_rdy = ($urandom_range(0, 3) != 0);
            reset   = ($urandom_range(0, 149) == 0);
         end
         q_vld = (evq.size() > 0);
         q_msg = q_vld ? evq[0] : 32'h0;
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b1; core_req = '0; core_last = '0; evq.delete();
      q_vld = 1'b0; q_msg = '0; enq_rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_log(input int n, input int bound, input string nm);
      int c = 0;
      while (lg_code.size() < n && c < bound) begin
         cyc();
         c++;
      end
      total++;
      if (lg_code.size() < n) begin
         bad++;
         $display("FAIL %s: timeout with %0d issues, expected %0d", nm, lg_code.size(), n);
      end
   endtask

   task automatic fill4();
      int c = 0;
      for (int i = 0; i < 4; i++) evq.push_back(32'h0100 + 32'(i));
      while (core_active != 4'hF && c < 40) begin
         cyc();
         c++;
      end
      chk("fill4", 128'(core_active), 128'(4'hF));
   endtask

   typedef struct {
      logic        qv;
      logic [31:0] qm;
      logic [3:0]  req;
      logic [3:0]  last;
      logic        x_deq;
      logic        x_rcv;
      logic [3:0]  x_gnt;
      logic [3:0]  x_evt;
      logic [1:0]  x_id;
      logic [3:0]  x_act;
      logic [31:0] x_mon;
   } vec_t;

   vec_t tv [14];

   initial begin
      int c;
      tv[0]  = '{1'b1, 32'h10, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h1, 2'd0, 4'h1, 32'h10};
      tv[1]  = '{1'b1, 32'h11, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 4'h1, 32'h10};
      tv[2]  = '{1'b1, 32'h11, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h2, 2'd1, 4'h3, 32'h11};
      tv[3]  = '{1'b1, 32'h12, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd1, 4'h3, 32'h11};
      tv[4]  = '{1'b1, 32'h12, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h4, 2'd2, 4'h7, 32'h12};
      tv[5]  = '{1'b1, 32'h13, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd2, 4'h7, 32'h12};
      tv[6]  = '{1'b1, 32'h13, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h8, 2'd3, 4'hF, 32'h13};
      tv[7]  = '{1'b1, 32'h14, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd3, 4'hF, 32'h13};
      tv[8]  = '{1'b1, 32'h14, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd3, 4'hF, 32'h13};
      tv[9]  = '{1'b1, 32'h14, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd3, 4'hF, 32'h13};
      tv[10] = '{1'b1, 32'h14, 4'h4, 4'h4, 1'b0, 1'b1, 4'h4, 4'h0, 2'd2, 4'hB, 32'hC0DE_0002};
      tv[11] = '{1'b1, 32'h14, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd2, 4'hB, 32'hC0DE_0002};
      tv[12] = '{1'b1, 32'h14, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h4, 2'd2, 4'hF, 32'h14};
      tv[13] = '{1'b0, 32'h00, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd2, 4'hF, 32'h14};

      reset = 1'b1; q_vld = 1'b0; q_msg = '0; enq_rdy = 1'b1; core_req = '0; core_last = '0;
      for (int i = 0; i < 4; i++) core_msg_a[i] = 32'hC0DE_0000 + 32'(i);
      @(negedge clk);
      @(negedge clk);
      chk("reset_state",
          {q_deq, enq_vld, mon_sent_vld, mon_rcv_vld, core_gnt, core_evt_vld, mon_core_id, core_active, mon_msg, enq_msg, core_evt_msg},
          '0);
      reset = 1'b0;

      for (int r = 0; r < 14; r++) begin
         @(negedge clk);
         q_vld = tv[r].qv; q_msg = tv[r].qm; core_req = tv[r].req; core_last = tv[r].last;
         @(posedge clk);
         #2;
         chk($sformatf("vec%0d", r),
             {q_deq, mon_sent_vld, enq_vld, mon_rcv_vld, core_gnt, core_evt_vld, mon_core_id, core_active, mon_msg},
             {tv[r].x_deq, tv[r].x_deq, 1'b0, tv[r].x_rcv, tv[r].x_gnt, tv[r].x_evt, tv[r].x_id, tv[r].x_act, tv[r].x_mon});
      end

      auto_env = 1;

      // Round-robin from a fresh pointer, one grant every two cycles.
      reset_dut();
      fill4();
      lg_code.delete(); lg_cyc.delete();
      core_last = 4'h0; core_req = 4'hF;
      wait_log(4, 40, "rr_order");
      for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), 128'(lg_at(k)), 128'(16 + k));
      for (int k = 1; k < 4; k++) chk($sformatf("rr_gap%0d", k), 128'(gap_at(k)), 128'(2));

      // Continuous return and dispatch pressure alternates the two kinds.
      reset_dut();
      lg_code.delete(); lg_cyc.delete();
      overlap = 0;
      for (int i = 0; i < 6; i++) evq.push_back(32'h0200 + 32'(i));
      keep0 = 1;
      wait_log(7, 60, "alternate");
      keep0 = 0;
      begin
         int exp_seq [7];
         exp_seq = '{0, 16, 1, 16, 2, 16, 3};
         for (int k = 0; k < 7; k++) chk($sformatf("alt%0d", k), 128'(lg_at(k)), 128'(exp_seq[k]));
      end
      chk("no_overlap", 128'(overlap), 128'(0));

      // Queue full: completions proceed, generated events wait.
      reset_dut();
      fill4();
      lg_code.delete(); lg_cyc.delete();
      enq_rdy = 1'b0; core_last = 4'b1000; core_req = 4'b1010;
      wait_log(1, 20, "stall_last");
      chk("stall_first", 128'(lg_at(0)), 128'(32 + 3));
      repeat (10) cyc();
      chk("stall_held", 128'(lg_code.size()), 128'(1));
      enq_rdy = 1'b1;
      wait_log(2, 20, "stall_release");
      chk("stall_second", 128'(lg_at(1)), 128'(16 + 1));

      // Reset landing on an issue cycle drops it and restarts arbitration at core 0.
      reset_dut();
      fill4();
      lg_code.delete(); lg_cyc.delete();
      core_last = 4'h0; core_req = 4'b0001;
      wait_log(1, 20, "pre_reset_grant");
      core_req = 4'b0110;
      c = 0;
      do begin
         cyc();
         c++;
      end while (core_gnt == 0 && c < 20);
      chk("pre_reset_ptr", 128'(core_gnt), 128'(4'b0010));
      reset = 1'b1;
      @(posedge clk);
      #2;
      chk("reset_in_issue",
          {q_deq, enq_vld, mon_sent_vld, mon_rcv_vld, core_gnt, core_evt_vld, mon_core_id, core_active, mon_msg},
          '0);
      reset_dut();
      fill4();
      lg_code.delete(); lg_cyc.delete();
      core_last = 4'h0; core_req = 4'hF;
      wait_log(1, 20, "post_reset_grant");
      chk("post_reset_first", 128'(lg_at(0)), 128'(16));

      // Random traffic, random enq_rdy and occasional resets, checked by the model.
      reset_dut();
      rnd = 1;
      repeat (3000) cyc();
      rnd = 0;
      reset = 1'b0;
      repeat (4) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
